// File: rtl/conf_pkg.sv
`default_nettype none
// conf_pkg: state encoding, default sizing and bit-timing helper shared by the
// configuration chain loader and its phase generator.
package conf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SETUP = 3'd2,
    ST_PH_A  = 3'd3,
    ST_GAP_A = 3'd4,
    ST_PH_B  = 3'd5,
    ST_GAP_B = 3'd6,
    ST_DONE  = 3'd7
  } conf_state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_PULSE_W    = 2;
  localparam int DEFAULT_GAP_W      = 1;

  function automatic int bit_period(input int pulse_w, input int gap_w);
    return 1 + 2 * pulse_w + 2 * gap_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conf_phase_gen.sv
`default_nettype none
// conf_phase_gen: per-bit strobe sequencer SETUP -> PH_A -> GAP_A -> PH_B -> GAP_B,
// with a bit_done flag on the final GAP_B cycle so the next bit can chain in.
module conf_phase_gen
  import conf_pkg::*;
#(
  parameter int PULSE_W = DEFAULT_PULSE_W,
  parameter int GAP_W   = DEFAULT_GAP_W
) (
  input  logic CLK,
  input  logic resetn,
  input  logic clear,
  input  logic step,
  output logic bit_done,
  output logic conf_clk,
  output logic conf_mode
);

  localparam int TIMER_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam logic [TIMER_W-1:0] PULSE_LAST = TIMER_W'(PULSE_W - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(GAP_W - 1);

  conf_state_t        phase;
  conf_state_t        phase_next;
  logic [TIMER_W-1:0] timer;
  logic               phase_last;
  logic               clk_d;
  logic               mode_d;

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      phase     <= ST_IDLE;
      timer     <= '0;
      conf_clk  <= 1'b0;
      conf_mode <= 1'b0;
    end else begin
      phase     <= phase_next;
      timer     <= (phase_next == phase) ? timer + 1'b1 : '0;
      conf_clk  <= clk_d;
      conf_mode <= mode_d;
    end
  end

  always_comb begin
    case (phase)
      ST_SETUP:           phase_last = 1'b1;
      ST_PH_A, ST_PH_B:   phase_last = (timer == PULSE_LAST);
      ST_GAP_A, ST_GAP_B: phase_last = (timer == GAP_LAST);
      default:            phase_last = 1'b0;
    endcase

    phase_next = phase;
    if (clear) begin
      phase_next = ST_IDLE;
    end else begin
      case (phase)
        ST_IDLE:  if (step) phase_next = ST_SETUP;
        ST_SETUP: phase_next = ST_PH_A;
        ST_PH_A:  if (phase_last) phase_next = ST_GAP_A;
        ST_GAP_A: if (phase_last) phase_next = ST_PH_B;
        ST_PH_B:  if (phase_last) phase_next = ST_GAP_B;
        // A step on the last gap cycle goes straight to the next SETUP.
        ST_GAP_B: if (phase_last) phase_next = step ? ST_SETUP : ST_IDLE;
        default:  phase_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bit_done = (phase == ST_GAP_B) && phase_last;
    clk_d    = (phase_next == ST_PH_A);
    mode_d   = (phase_next == ST_PH_B);
  end

endmodule
`default_nettype wire

// File: rtl/conf_chain_loader.sv
`default_nettype none
// conf_chain_loader: fetches configuration words and shifts CHAIN_LEN bits MSB
// first into a two-phase latch chain; ST_SETUP here spans a whole bit in flight.
module conf_chain_loader
  import conf_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CHAIN_LEN  = 1024,
  parameter int PULSE_W    = DEFAULT_PULSE_W,
  parameter int GAP_W      = DEFAULT_GAP_W
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  CONFin,
  output logic                  conf_clk,
  output logic                  conf_mode,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int WB_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  TOP_BIT  = WB_W'(DATA_WIDTH - 1);

  conf_state_t           state;
  conf_state_t           state_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_shift;
  logic [CNT_W-1:0]      bit_cnt;
  logic [WB_W-1:0]       word_bit;
  logic                  bit_done;
  logic                  step;
  logic                  accept;
  logic                  advance;
  logic                  count_up;

  assign shreg_shift = shreg << 1;

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      word_bit <= '0;
      CONFin   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      done  <= (state_next == ST_DONE);

      if (state == ST_IDLE) begin
        bit_cnt <= '0;
      end else if (count_up) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (accept) begin
        shreg    <= word_data;
        word_bit <= TOP_BIT;
      end else if (advance) begin
        shreg    <= shreg_shift;
        word_bit <= word_bit - 1'b1;
      end

      // The serial bit is set up on SETUP entry and held until the next one.
      if (state_next == ST_IDLE || state_next == ST_DONE) begin
        CONFin <= 1'b0;
      end else if (accept) begin
        CONFin <= word_data[DATA_WIDTH-1];
      end else if (advance) begin
        CONFin <= shreg_shift[DATA_WIDTH-1];
      end
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    count_up   = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_next = ST_FETCH;
        ST_FETCH: begin
          if (word_valid) begin
            state_next = ST_SETUP;
            accept     = 1'b1;
          end
        end
        ST_SETUP: begin
          if (bit_done) begin
            if (bit_cnt == LAST_BIT) begin
              state_next = ST_DONE;
            end else begin
              count_up = 1'b1;
              if (word_bit == '0) begin
                state_next = ST_FETCH;
              end else begin
                advance = 1'b1;
              end
            end
          end
        end
        ST_DONE:  state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    word_ready = (state == ST_FETCH);
    step       = accept || advance;
  end

  conf_phase_gen #(
    .PULSE_W (PULSE_W),
    .GAP_W   (GAP_W)
  ) u_phase_gen (
    .CLK       (CLK),
    .resetn    (resetn),
    .clear     (abort),
    .step      (step),
    .bit_done  (bit_done),
    .conf_clk  (conf_clk),
    .conf_mode (conf_mode)
  );

endmodule
`default_nettype wire

// File: tb/tb_conf_chain_loader.sv
`default_nettype none
// tb_conf_chain_loader: random word loads scored against the expected bitstream
// (concatenated words, MSB first, truncated to CHAIN_LEN) plus strobe timing rules.
module tb_conf_chain_loader;

  localparam int DW     = 4;
  localparam int CL     = 10;
  localparam int PW     = 2;
  localparam int GW     = 1;
  localparam int WORDS  = (CL + DW - 1) / DW;
  localparam int PERIOD = 1 + 2 * PW + 2 * GW;

  logic          CLK = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] word_data = '0;
  logic          word_valid = 1'b0;
  logic          word_ready, CONFin, conf_clk, conf_mode, busy, done;

  int tests = 0;
  int fails = 0;
  bit exp_bits[$];
  int exp_done[$];
  int bits_fed = 0;
  int done_total = 0;
  bit mon_en = 1'b0;

  conf_chain_loader #(
    .DATA_WIDTH (DW),
    .CHAIN_LEN  (CL),
    .PULSE_W    (PW),
    .GAP_W      (GW)
  ) dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .CONFin     (CONFin),
    .conf_clk   (conf_clk),
    .conf_mode  (conf_mode),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0, rise_cyc = 0, ready_since = 0, hs_cnt = 0, bits_seen = 0;
  int clk_run = 0, mode_run = 0;
  bit have_last = 1'b0, cut = 1'b0;
  logic prev_clk = 1'b0, prev_mode = 1'b0, prev_conf = 1'b0;
  logic prev_ready = 1'b0, prev_done = 1'b0;

  always @(negedge CLK) begin
    if (mon_en) begin
      cyc++;
      if (conf_clk || conf_mode)
        check("strobe_overlap", int'(conf_clk && conf_mode), 0);
      if ((conf_clk || conf_mode) && (prev_clk || prev_mode))
        check("confin_stable", int'(CONFin), int'(prev_conf));
      if (word_ready) begin
        check("stall_strobes_low", int'(conf_clk || conf_mode), 0);
        if (prev_ready) check("stall_confin", int'(CONFin), int'(prev_conf));
        ready_since++;
        if (word_valid) hs_cnt++;
      end
      if (conf_clk && !prev_clk) begin
        check("bit_queued", int'(exp_bits.size() > 0), 1);
        if (exp_bits.size() > 0) check("confin_bit", int'(CONFin), int'(exp_bits.pop_front()));
        if (have_last) check("bit_period", cyc - rise_cyc, PERIOD + ready_since);
        rise_cyc = cyc;
        ready_since = 0;
        have_last = 1'b1;
        cut = 1'b0;
        bits_seen++;
      end
      if (conf_mode && !prev_mode) check("ab_spacing", cyc - rise_cyc, PW + GW);
      if (conf_clk) clk_run++;
      else if (prev_clk) begin
        if (!cut) check("pa_width", clk_run, PW);
        clk_run = 0;
      end
      if (conf_mode) mode_run++;
      else if (prev_mode) begin
        if (!cut) check("pb_width", mode_run, PW);
        mode_run = 0;
      end
      if (done) begin
        done_total++;
        check("done_expected", int'(exp_done.size() > 0), 1);
        if (exp_done.size() > 0) void'(exp_done.pop_front());
        check("done_bits_left", exp_bits.size(), 0);
        check("done_bit_count", bits_seen, CL);
        check("done_words", hs_cnt, WORDS);
        check("done_confin", int'(CONFin), 0);
        check("busy_in_done", int'(busy), 1);
        hs_cnt = 0;
        bits_seen = 0;
        have_last = 1'b0;
        ready_since = 0;
      end else if (prev_done) begin
        check("busy_after_done", int'(busy), 0);
      end
      if (!resetn || abort) begin
        hs_cnt = 0;
        bits_seen = 0;
        have_last = 1'b0;
        ready_since = 0;
        cut = 1'b1;
      end
      prev_clk   = conf_clk;
      prev_mode  = conf_mode;
      prev_conf  = CONFin;
      prev_ready = word_ready;
      prev_done  = done;
    end
  end

  // ---------------- driver ----------------
  // stall = number of FETCH cycles the word is withheld after word_ready rises.
  task automatic feed_word(input logic [DW-1:0] w, input int stall);
    int n;
    for (int i = DW - 1; i >= 0; i--) begin
      if (bits_fed < CL) begin
        exp_bits.push_back(w[i]);
        bits_fed++;
      end
    end
    if (stall > 0) begin
      n = 0;
      do begin @(negedge CLK); n++; end while (!word_ready && n < 400);
      repeat (stall - 1) @(negedge CLK);
      @(posedge CLK); #1;
    end
    word_data  = w;
    word_valid = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!word_ready && n < 400);
    check("word_accept", int'(word_ready), 1);
    @(posedge CLK); #1;
    word_valid = 1'b0;
    word_data  = DW'($urandom);
  endtask

  task automatic run_load(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input logic [DW-1:0] w2, input int s0, input int s1,
                          input int s2, input bit hold_start);
    logic [DW-1:0] w[3];
    int s[3];
    int n;
    longint t0;
    w[0] = w0; w[1] = w1; w[2] = w2;
    s[0] = s0; s[1] = s1; s[2] = s2;
    bits_fed = 0;
    exp_done.push_back(1);
    start = 1'b1;
    t0 = $time;
    tick();
    if (!hold_start) start = 1'b0;
    for (int k = 0; k < WORDS; k++) feed_word(w[k], s[k]);
    start = 1'b0;
    n = 0;
    do begin @(negedge CLK); n++; end while (!done && n < 1000);
    check("done_seen", int'(done), 1);
    check("load_duration", int'(($time - t0) / 10), 1 + WORDS + CL * PERIOD + s0 + s1 + s2);
    tick();
    tick();
  endtask

  task automatic wait_strobe_rises(input bit on_mode, input int count);
    int n, rises;
    logic p;
    n = 0;
    rises = 0;
    p = on_mode ? conf_mode : conf_clk;
    do begin
      @(negedge CLK);
      n++;
      if ((on_mode ? conf_mode : conf_clk) && !p) rises++;
      p = on_mode ? conf_mode : conf_clk;
    end while (rises < count && n < 300);
    check("reach_strobe", rises, count);
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_conf_clk"}, int'(conf_clk), 0);
    check({tag, "_conf_mode"}, int'(conf_mode), 0);
    check({tag, "_confin"}, int'(CONFin), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_ready"}, int'(word_ready), 0);
  endtask

  initial begin
    int d0;
    repeat (3) tick();
    check_all_low("reset");
    resetn = 1'b1;
    mon_en = 1'b1;
    tick();

    // Directed loads: A,5 then a partial last word; then the same with a stall.
    run_load(4'hA, 4'h5, 4'hF, 0, 0, 0, 1'b0);
    run_load(4'hA, 4'h5, 4'hF, 0, 10, 0, 1'b0);
    run_load(4'hF, 4'h8, 4'h3, 0, 0, 0, 1'b1);

    for (int r = 0; r < 6; r++)
      run_load(DW'($urandom), DW'($urandom), DW'($urandom), $urandom_range(6, 0),
               $urandom_range(6, 0), $urandom_range(6, 0), 1'($urandom));

    // Abort during PH_B of bit 3.
    bits_fed = 0;
    start = 1'b1; tick(); start = 1'b0;
    feed_word(DW'($urandom), 0);
    wait_strobe_rises(1'b1, 4);
    @(posedge CLK); #1;
    abort = 1'b1;
    d0 = done_total;
    tick();
    abort = 1'b0;
    check_all_low("abort");
    exp_bits.delete();
    repeat (20) tick();
    check("abort_no_done", done_total, d0);
    check("abort_idle", int'(busy), 0);
    run_load(DW'($urandom), DW'($urandom), DW'($urandom), 0, 2, 0, 1'b0);

    // Reset for one edge during PH_A of bit 1.
    bits_fed = 0;
    start = 1'b1; tick(); start = 1'b0;
    feed_word(DW'($urandom), 0);
    wait_strobe_rises(1'b0, 2);
    @(posedge CLK); #1;
    resetn = 1'b0;
    d0 = done_total;
    tick();
    resetn = 1'b1;
    check_all_low("midreset");
    exp_bits.delete();
    repeat (5) tick();
    check("midreset_no_done", done_total, d0);
    run_load(DW'($urandom), DW'($urandom), DW'($urandom), 1, 0, 3, 1'b0);

    repeat (5) tick();
    check("no_pending_done", exp_done.size(), 0);
    check("no_pending_bits", exp_bits.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
